// File: rtl/instr_aligner_pkg.sv
// Shared types and codes for the instruction aligner: FSM state and fetch error encoding.
package instr_aligner_pkg;

  localparam int INSTR_W = 32;
  localparam int HALF_W  = 16;
  localparam int FERR_W  = 3;

  typedef enum logic {
    AL_EMPTY = 1'b0,
    AL_UPPER = 1'b1
  } al_state_t;

  localparam logic [FERR_W-1:0] FETCH_NONE  = 3'd0;
  localparam logic [FERR_W-1:0] FETCH_BSERR = 3'd1;
  localparam logic [FERR_W-1:0] FETCH_UCERR = 3'd2;
  localparam logic [FERR_W-1:0] FETCH_INMIS = 3'd3;

endpackage

// File: rtl/instr_aligner.sv
// Turns 32-bit fetch words into one aligned RVI/RVC instruction per cycle, joining
// straddling RVI halves and flagging predictions that would split an RVI instruction.
module instr_aligner
  import instr_aligner_pkg::*;
(
  input  logic               s_clk_i,
  input  logic               s_resetn_i,
  input  logic               s_flush_i,
  input  logic               s_fetch_valid_i,
  input  logic [INSTR_W-1:0] s_fetch_data_i,
  input  logic               s_fetch_start_i,
  input  logic [FERR_W-1:0]  s_fetch_error_i,
  input  logic               s_fetch_pred_i,
  output logic               s_fetch_ready_o,
  output logic               s_valid_o,
  input  logic               s_ready_i,
  output logic [INSTR_W-1:0] s_instr_o,
  output logic [FERR_W-1:0]  s_fetch_error_o,
  output logic               s_align_error_o,
  output logic               s_prediction_o
);

  al_state_t           state, nxt_state;
  logic [HALF_W-1:0]   hold, nxt_hold;
  logic                hold_pred, nxt_hold_pred;

  logic                vld_p1;
  logic [INSTR_W-1:0]  instr_p1;
  logic [FERR_W-1:0]   ferr_p1;
  logic                align_p1;
  logic                pred_p1;

  logic                load;
  logic                avail;
  logic                consume;
  logic                capture;
  logic                advance;
  logic [INSTR_W-1:0]  e_instr;
  logic [FERR_W-1:0]   e_err;
  logic                e_align;
  logic                e_pred;
  logic [HALF_W-1:0]   lo_half, hi_half;

  assign load    = ~vld_p1 | s_ready_i;
  assign lo_half = s_fetch_data_i[15:0];
  assign hi_half = s_fetch_data_i[31:16];

  always_comb begin
    avail         = 1'b0;
    consume       = 1'b0;
    capture       = 1'b0;
    nxt_state     = state;
    nxt_hold      = hold;
    nxt_hold_pred = hold_pred;
    e_instr       = '0;
    e_err         = FETCH_NONE;
    e_align       = 1'b0;
    e_pred        = 1'b0;
    case (state)
      AL_EMPTY: begin
        if (s_fetch_valid_i) begin
          consume = 1'b1;
          if (s_fetch_error_i != FETCH_NONE) begin
            avail   = 1'b1;
            e_instr = s_fetch_data_i;
            e_err   = s_fetch_error_i;
            e_pred  = s_fetch_pred_i;
          end else if (!s_fetch_start_i) begin
            avail = 1'b1;
            if (lo_half[1:0] == 2'b11) begin
              e_instr = s_fetch_data_i;
              e_pred  = s_fetch_pred_i;
            end else begin
              e_instr       = {16'h0000, lo_half};
              nxt_hold      = hi_half;
              nxt_hold_pred = s_fetch_pred_i;
              nxt_state     = AL_UPPER;
            end
          end else if (hi_half[1:0] != 2'b11) begin
            avail   = 1'b1;
            e_instr = {16'h0000, hi_half};
            e_pred  = s_fetch_pred_i;
          end else if (!s_fetch_pred_i) begin
            // Lower half of a straddling RVI: park it, nothing to emit yet.
            capture       = 1'b1;
            nxt_hold      = hi_half;
            nxt_hold_pred = 1'b0;
            nxt_state     = AL_UPPER;
          end else begin
            avail   = 1'b1;
            e_instr = {16'h0000, hi_half};
            e_align = 1'b1;
            e_pred  = 1'b1;
          end
        end
      end
      AL_UPPER: begin
        if (hold[1:0] != 2'b11) begin
          avail     = 1'b1;
          e_instr   = {16'h0000, hold};
          e_pred    = hold_pred;
          nxt_state = AL_EMPTY;
        end else if (hold_pred) begin
          // Predictor redirected in the middle of an RVI: report, never join.
          avail     = 1'b1;
          e_instr   = {16'h0000, hold};
          e_align   = 1'b1;
          e_pred    = 1'b1;
          nxt_state = AL_EMPTY;
        end else if (s_fetch_valid_i) begin
          avail   = 1'b1;
          consume = 1'b1;
          e_instr = {lo_half, hold};
          if (s_fetch_error_i != FETCH_NONE) begin
            e_err     = s_fetch_error_i;
            nxt_state = AL_EMPTY;
          end else begin
            nxt_hold      = hi_half;
            nxt_hold_pred = s_fetch_pred_i;
          end
        end
      end
      default: nxt_state = AL_EMPTY;
    endcase
  end

  assign advance         = ((avail & load) | capture) & ~s_flush_i;
  assign s_fetch_ready_o = s_resetn_i & s_fetch_valid_i & consume & (load | capture) & ~s_flush_i;

  // Stage p0 -> p1: aligner state and output instruction register
  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      state     <= AL_EMPTY;
      hold      <= '0;
      hold_pred <= 1'b0;
    end else if (s_flush_i) begin
      state     <= AL_EMPTY;
      hold_pred <= 1'b0;
    end else if (advance) begin
      state     <= nxt_state;
      hold      <= nxt_hold;
      hold_pred <= nxt_hold_pred;
    end
  end

  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      vld_p1   <= 1'b0;
      instr_p1 <= '0;
      ferr_p1  <= FETCH_NONE;
      align_p1 <= 1'b0;
      pred_p1  <= 1'b0;
    end else if (s_flush_i) begin
      vld_p1 <= 1'b0;
    end else if (load) begin
      vld_p1 <= avail;
      if (avail) begin
        instr_p1 <= e_instr;
        ferr_p1  <= e_err;
        align_p1 <= e_align;
        pred_p1  <= e_pred;
      end
    end
  end

  assign s_valid_o       = vld_p1;
  assign s_instr_o       = instr_p1;
  assign s_fetch_error_o = ferr_p1;
  assign s_align_error_o = align_p1;
  assign s_prediction_o  = pred_p1;

endmodule

// File: tb/tb_instr_aligner.sv
// Directed scoreboard bench for instr_aligner: driver queues expected instructions, monitor checks them.
module tb_instr_aligner;
  import instr_aligner_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        fv;
  logic [31:0] fdata;
  logic        fstart;
  logic [2:0]  ferr;
  logic        fpred;
  logic        fready;
  logic        valid;
  logic        ready;
  logic [31:0] instr;
  logic [2:0]  oerr;
  logic        oalign;
  logic        opred;

  typedef struct packed {
    logic [31:0] instr;
    logic [2:0]  err;
    logic        align;
    logic        pred;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  instr_aligner dut (
    .s_clk_i         (clk),
    .s_resetn_i      (rst_n),
    .s_flush_i       (flush),
    .s_fetch_valid_i (fv),
    .s_fetch_data_i  (fdata),
    .s_fetch_start_i (fstart),
    .s_fetch_error_i (ferr),
    .s_fetch_pred_i  (fpred),
    .s_fetch_ready_o (fready),
    .s_valid_o       (valid),
    .s_ready_i       (ready),
    .s_instr_o       (instr),
    .s_fetch_error_o (oerr),
    .s_align_error_o (oalign),
    .s_prediction_o  (opred)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req)
      $display("FAIL %s: got %h expected %h", name, act, req);
    else
      passes++;
  endtask

  task automatic push(input logic [31:0] i, input logic [2:0] e, input logic a, input logic p);
    exp_t x;
    x.instr = i; x.err = e; x.align = a; x.pred = p;
    exp_q.push_back(x);
  endtask

  // Called at posedge+1; returns at posedge+1 after the word is consumed.
  task automatic send(input logic [31:0] d, input logic st, input logic [2:0] e,
                      input logic p, output int waits);
    fv = 1'b1; fdata = d; fstart = st; ferr = e; fpred = p;
    waits = 0;
    forever begin
      @(negedge clk);
      if (fready) break;
      waits++;
      if (waits > 50) begin
        checks++;
        $display("FAIL send_timeout: word %h never consumed", d);
        break;
      end
    end
    @(posedge clk); #1;
    fv = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && valid && ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", {27'd0, instr, oerr, oalign, opred}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        check("instr_out", {27'd0, instr, oerr, oalign, opred}, {27'd0, x});
      end
    end
  end

  initial begin
    int w;
    rst_n = 1'b0; flush = 1'b0; ready = 1'b1;
    fv = 1'b1; fdata = 32'h0000_0013; fstart = 1'b0; ferr = FETCH_NONE; fpred = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", {63'd0, valid}, 64'd0);
    check("rst_instr", {32'd0, instr}, 64'd0);
    check("rst_err", {61'd0, oerr}, 64'd0);
    check("rst_align", {63'd0, oalign}, 64'd0);
    check("rst_pred", {63'd0, opred}, 64'd0);
    check("rst_fetch_ready", {63'd0, fready}, 64'd0);
    fv = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Two plain RVI words back to back
    push(32'h0000_0013, FETCH_NONE, 1'b0, 1'b0);
    push(32'h0010_0093, FETCH_NONE, 1'b0, 1'b0);
    send(32'h0000_0013, 1'b0, FETCH_NONE, 1'b0, w);
    send(32'h0010_0093, 1'b0, FETCH_NONE, 1'b0, w);
    check("rvi_back_to_back_waits", 64'(w), 64'd0);

    // RVC low half, then a straddling RVI, then the RVC left in hold
    push(32'h0000_4505, FETCH_NONE, 1'b0, 1'b0);
    push(32'h0013_0013, FETCH_NONE, 1'b0, 1'b0);
    push(32'h0000_0000, FETCH_NONE, 1'b0, 1'b0);
    send(32'h0013_4505, 1'b0, FETCH_NONE, 1'b0, w);
    send(32'h0000_0013, 1'b0, FETCH_NONE, 1'b0, w);
    check("straddle_waits", 64'(w), 64'd0);

    // Start at upper half: RVI with prediction -> align error; RVC with prediction
    push(32'h0000_0013, FETCH_NONE, 1'b1, 1'b1);
    push(32'h0010_0093, FETCH_NONE, 1'b0, 1'b0);
    push(32'h0000_4505, FETCH_NONE, 1'b0, 1'b1);
    send(32'h0013_0000, 1'b1, FETCH_NONE, 1'b1, w);
    send(32'h0010_0093, 1'b0, FETCH_NONE, 1'b0, w);
    send(32'h4505_0000, 1'b1, FETCH_NONE, 1'b1, w);

    // Captured RVI half joined with a bus-error word, then low-half decode
    push(32'h5678_0093, FETCH_BSERR, 1'b0, 1'b0);
    push(32'h0000_0001, FETCH_NONE, 1'b0, 1'b0);
    push(32'h0000_4505, FETCH_NONE, 1'b0, 1'b0);
    send(32'h0093_0000, 1'b1, FETCH_NONE, 1'b0, w);
    send(32'h1234_5678, 1'b0, FETCH_BSERR, 1'b0, w);
    send(32'h4505_0001, 1'b0, FETCH_NONE, 1'b0, w);
    repeat (4) @(posedge clk); #1;

    // Stall with an RVI half held, then flush
    ready = 1'b0;
    send(32'h0013_4505, 1'b0, FETCH_NONE, 1'b0, w);
    fv = 1'b1; fdata = 32'h0000_0013; fstart = 1'b0; ferr = FETCH_NONE; fpred = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_valid", {63'd0, valid}, 64'd1);
      check("stall_instr", {32'd0, instr}, 64'h0000_4505);
      check("stall_fetch_ready", {63'd0, fready}, 64'd0);
    end
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_fetch_ready", {63'd0, fready}, 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; fv = 1'b0;
    check("flush_valid", {63'd0, valid}, 64'd0);
    ready = 1'b1;
    push(32'h0010_0093, FETCH_NONE, 1'b0, 1'b0);
    send(32'h0010_0093, 1'b0, FETCH_NONE, 1'b0, w);
    repeat (3) @(posedge clk); #1;

    // Asynchronous reset while an RVI half is held
    send(32'h0013_4505, 1'b0, FETCH_NONE, 1'b0, w);
    check("pre_reset_valid", {63'd0, valid}, 64'd1);
    check("pre_reset_instr", {32'd0, instr}, 64'h0000_4505);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_valid", {63'd0, valid}, 64'd0);
    check("async_rst_instr", {32'd0, instr}, 64'd0);
    check("async_rst_err", {61'd0, oerr}, 64'd0);
    check("async_rst_pred", {63'd0, opred}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    push(32'h0010_0093, FETCH_NONE, 1'b0, 1'b0);
    send(32'h0010_0093, 1'b0, FETCH_NONE, 1'b0, w);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/instr_aligner.md
# instr_aligner

Sequences the decoder's input: consumes 32-bit fetch words and presents exactly one aligned RVI or RVC instruction per cycle to the ID-stage decoder, with its fetch error, prediction flag and alignment-error flag. It sits between the fetch buffer and the decoder. It handles halfword-aligned RVI instructions that straddle two fetch words. It also detects predictions that would split an RVI instruction, and reports them as align errors so the decoder raises its predictor-restart misconduct.

## Interface
- No parameters.
- s_clk_i  in  1  clock.
- s_resetn_i  in  1  reset. Asynchronous, active-low.
- s_flush_i  in  1  pipeline flush/redirect. Clears all state.
- s_fetch_valid_i  in  1  fetch word available.
- s_fetch_data_i  in  32  fetch word.
- s_fetch_start_i  in  1  first instruction starts at upper halfword (redirect target bit 1).
- s_fetch_error_i  in  3  fetch error code (FETCH_* encoding, 0 = none).
- s_fetch_pred_i  in  1  predictor redirected after the last instruction ending in this word.
- s_fetch_ready_o  out  1  word consumed this cycle (combinational).
- s_valid_o  out  1  instruction register valid.
- s_ready_i  in  1  decode stage accepts.
- s_instr_o  out  32  aligned instruction. Upper 16 bits are 0 for RVC.
- s_fetch_error_o  out  3  error attached to instruction.
- s_align_error_o  out  1  misaligned prediction.
- s_prediction_o  out  1  prediction attached to instruction.

## Operation
- The output register loads when `load = ~s_valid_o | s_ready_i` and an instruction is available.
- A halfword is RVC when bits[1:0] != 2'b11.
- Internal state:
  - FSM states EMPTY and UPPER.
  - 16-bit hold register plus hold_pred.
  - In UPPER, hold contains the unprocessed upper half of the last consumed word.
- EMPTY, fetch valid, error != 0: emit the whole word with its error and pred. Consume the word; stay EMPTY.
- EMPTY, start=0:
  - Low half RVI: emit the full word with its pred. Consume; stay EMPTY.
  - Low half RVC: emit the low half, pred=0. Consume; hold ← upper half, hold_pred ← word pred; go to UPPER.
- EMPTY, start=1:
  - Upper half RVC: emit it with the word's pred. Consume; stay EMPTY.
  - Upper half RVI, pred=0: capture it into hold without emitting. Consume; go to UPPER.
  - Upper half RVI, pred=1: emit it with align error=1. Consume; stay EMPTY.
- UPPER, hold RVC: emit the hold halfword with hold_pred, without consuming fetch. Go to EMPTY.
- UPPER, hold RVI, hold_pred=1: emit hold with align error=1 and pred=1, without consuming fetch. Go to EMPTY.
- UPPER, hold RVI, hold_pred=0, fetch valid: emit {fetch[15:0], hold}.
  - Fetch error != 0: output error = fetch error. Consume; go to EMPTY.
  - Otherwise: pred = 0. Consume; hold ← fetch[31:16], hold_pred ← fetch pred; stay UPPER.
- s_fetch_start_i is ignored in UPPER.
- s_fetch_ready_o = load & s_fetch_valid_i & (the case consumes the word) & ~s_flush_i.
  - The start=1 capture into hold (no emit) consumes regardless of load.
- Flush:
  - Has priority over everything; applies the same cycle.
  - Next cycle: state EMPTY, hold_pred 0, s_valid_o 0.
  - No word is consumed in the flush cycle.

## Timing
- Reset values: s_valid_o 0, s_instr_o 0, s_fetch_error_o 0, s_align_error_o 0, s_prediction_o 0, state EMPTY, hold 0, hold_pred 0.
- s_fetch_ready_o is 0 while s_resetn_i is low.
- Latency: 1 cycle, fetch word to s_valid_o.
- One instruction per cycle sustained, including an RVC/RVI mix with straddles.
- When s_ready_i=0 and s_valid_o=1, all outputs hold and no word is consumed.
- An asserted reset mid-operation drops any held halfword.

## Structure
- Add the aligner state enum (AL_EMPTY, AL_UPPER) to p_hardisc; reuse the existing FETCH_* codes.
- Single module, no sub-module; RVC detection is an inline comparison.
- Target size: about 180 lines of RTL.

## Test plan
- Reset, then words 0x00000013 and 0x00100093 with start=0 → two RVI outputs on consecutive cycles, error 0, pred 0.
- Word 0x00134505 → RVC 0x00004505 emitted, then hold 0x0013 in UPPER. Next word 0x00000013 → RVI output 0x00130013.
- Start=1, word upper half RVI with pred=1 → s_align_error_o=1, s_prediction_o=1, state EMPTY.
- UPPER holding RVI + next word with FETCH_BSERR → instruction output with error=FETCH_BSERR, state EMPTY, next word decoded from its low half.
- s_ready_i low for 3 cycles while outputs valid → outputs stable, s_fetch_ready_o=0. Flush during the stall → s_valid_o=0 next cycle, hold discarded.
- Reset asserted in UPPER → all outputs 0 and EMPTY immediately. After release, first word with start=0 decodes from its low half.
